// File: rtl/data_mem_arb_pkg.sv
// Shared types and encodings for the data memory arbiter.
package data_mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StOwn0 = 2'b01,
        StOwn1 = 2'b10
    } arb_state_e;

    localparam logic [1:0] OWNER_IDLE = 2'b00;
    localparam logic [1:0] OWNER_M0   = 2'b01;
    localparam logic [1:0] OWNER_M1   = 2'b10;

endpackage

// File: rtl/rr_grant_fsm.sv
// Round-robin grant decision with a bounded burst hold for two requesters.
module rr_grant_fsm
    import data_mem_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [1:0] owner
);

    localparam int unsigned CntW = $clog2(MAX_BURST + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BURST);

    arb_state_e      state_q;
    logic            last_owner_q;
    logic [CntW-1:0] burst_cnt_q;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            unique case ({req1, req0})
                2'b01: gnt0 = 1'b1;
                2'b10: gnt1 = 1'b1;
                2'b11: begin
                    unique case (state_q)
                        StOwn0: begin
                            gnt0 = (burst_cnt_q < MaxCnt);
                            gnt1 = !(burst_cnt_q < MaxCnt);
                        end
                        StOwn1: begin
                            gnt1 = (burst_cnt_q < MaxCnt);
                            gnt0 = !(burst_cnt_q < MaxCnt);
                        end
                        default: begin
                            // From idle a tie goes to whoever did not own last.
                            gnt0 = last_owner_q;
                            gnt1 = !last_owner_q;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_owner_q <= 1'b1;
            burst_cnt_q  <= '0;
            owner        <= OWNER_IDLE;
        end else if (gnt0 || gnt1) begin
            if (state_q == (gnt0 ? StOwn0 : StOwn1)) begin
                burst_cnt_q <= (burst_cnt_q == MaxCnt) ? MaxCnt : burst_cnt_q + CntW'(1);
            end else begin
                burst_cnt_q <= CntW'(1);
            end
            state_q      <= gnt0 ? StOwn0 : StOwn1;
            last_owner_q <= gnt1;
            owner        <= gnt0 ? OWNER_M0 : OWNER_M1;
        end else begin
            state_q     <= StIdle;
            burst_cnt_q <= '0;
            owner       <= OWNER_IDLE;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-port data memory between the CPU (port 0) and a secondary master (port 1).
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wd,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rd,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wd,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rd,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd,
    output logic [1:0]            owner
);

    logic                  gnt0, gnt1;
    logic                  rvalid0_q, rvalid1_q;
    logic [DATA_WIDTH-1:0] rd0_q, rd1_q;

    rr_grant_fsm #(
        .MAX_BURST(MAX_BURST)
    ) u_rr_grant_fsm (
        .clk  (clk),
        .rst  (rst),
        .req0 (m0_req),
        .req1 (m1_req),
        .gnt0 (gnt0),
        .gnt1 (gnt1),
        .owner(owner)
    );

    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;

    always_comb begin
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        if (gnt0) begin
            mem_we   = m0_we;
            mem_re   = !m0_we;
            mem_addr = m0_addr;
            mem_wd   = m0_wd;
        end else if (gnt1) begin
            mem_we   = m1_we;
            mem_re   = !m1_we;
            mem_addr = m1_addr;
            mem_wd   = m1_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rd0_q     <= '0;
            rd1_q     <= '0;
        end else begin
            rvalid0_q <= gnt0 && !m0_we;
            rvalid1_q <= gnt1 && !m1_we;
            if (gnt0 && !m0_we) rd0_q <= mem_rd;
            if (gnt1 && !m1_we) rd1_q <= mem_rd;
        end
    end

    // A read returning while reset is asserted is dropped rather than delivered.
    assign m0_rvalid = rvalid0_q && !rst;
    assign m1_rvalid = rvalid1_q && !rst;
    assign m0_rd     = rd0_q;
    assign m1_rd     = rd1_q;

endmodule
